// File: rtl/prewish5k_input_responder.sv
// prewish5k_input_responder
// Owns the board's raw user inputs (main button on bit 0 plus up to seven
// further active-high lines). Each bit is synchronised and debounced on its
// own. The debounced state, ANDed with the requested mask, is returned to the
// initiator through a single-cycle STB_I -> STB_O request/acknowledge exchange.
// A free-running counter drives a heartbeat LED.

module prewish5k_input_responder #(
    parameter int unsigned DEBOUNCE_BITS = 4,
    parameter int unsigned ALIVE_BITS    = 22
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    input  logic [7:0] i_inputs,
    output logic       o_alive
);

    localparam int unsigned NBITS = 8;

    // Handshake FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Debounce counter saturation value: reaching it with a further
    // disagreement commits the new level instead of wrapping.
    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

    // Two-stage synchroniser
    logic [NBITS-1:0] sync1_q;
    logic [NBITS-1:0] sync2_q;

    // Debounce state
    logic [NBITS-1:0]         stable_q;
    logic [NBITS-1:0]         stable_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q [NBITS];
    logic [DEBOUNCE_BITS-1:0] cnt_d [NBITS];

    // Handshake state
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [NBITS-1:0] mask_q;
    logic [NBITS-1:0] mask_d;
    logic [NBITS-1:0] dat_q;
    logic [NBITS-1:0] dat_d;
    logic             stb_q;
    logic             stb_d;

    // Heartbeat
    logic [ALIVE_BITS-1:0] alive_q;
    logic [ALIVE_BITS-1:0] alive_d;

    // Bring the asynchronous pads into the CLK_I domain
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_inputs;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: count consecutive disagreements, commit on saturation
    always_comb begin
        stable_d = stable_q;
        for (int unsigned n = 0; n < NBITS; n++) begin
            cnt_d[n] = '0;
            if (sync2_q[n] != stable_q[n]) begin
                if (cnt_q[n] == CNT_MAX) begin
                    stable_d[n] = sync2_q[n];
                    cnt_d[n]    = '0;
                end else begin
                    cnt_d[n] = cnt_q[n] + 1'b1;
                end
            end
        end
    end

    // Debounce registers
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            stable_q <= '0;
            for (int unsigned n = 0; n < NBITS; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int unsigned n = 0; n < NBITS; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Request/acknowledge sequencing; STB_I is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dat_d   = dat_q;
        stb_d   = stb_q;
        case (state_q)
            ST_IDLE: begin
                if (STB_I) begin
                    mask_d  = DAT_I;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Uses the pre-edge stable value; a commit on this same
                // edge shows up only in the following response.
                dat_d   = stable_q & mask_q;
                stb_d   = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake registers; reset aborts any transaction in flight
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            dat_q   <= '0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
        end
    end

    // Free-running heartbeat, wraps naturally
    always_comb begin
        alive_d = alive_q + 1'b1;
    end

    // Heartbeat register
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            alive_q <= '0;
        end else begin
            alive_q <= alive_d;
        end
    end

    assign STB_O   = stb_q;
    assign DAT_O   = dat_q;
    assign o_alive = alive_q[ALIVE_BITS-1];

endmodule
